// File: rtl/craft_test_harness_pkg.sv
// Shared constants and types for the ADC zero-crossing bring-up harness.
package craft_harness_pkg;

  localparam int         DATA_W        = 12;
  localparam int         HYST          = 16;
  localparam int         NUM_CROSSINGS = 4;
  localparam int         MIN_GAP       = 8;
  localparam logic [7:0] BIAS_CODE     = 8'h80;

  // One extra bit so the difference of two unsigned codes never overflows.
  typedef logic signed [DATA_W:0] diff_t;

  typedef enum logic {
    NEG = 1'b0,
    POS = 1'b1
  } cmp_state_e;

endpackage

// File: rtl/craft_test_harness_if.sv
// Stimulus/result bundle between the bring-up driver and the harness.
interface craft_test_harness_if;
  import craft_harness_pkg::*;

  logic              io_core_reset;
  logic              io_dsp_reset;
  logic              io_adcclkreset;
  logic [DATA_W-1:0] io_ADCINP;
  logic [DATA_W-1:0] io_ADCINM;
  logic [7:0]        io_ADCBIAS;
  logic              io_success;

  modport master (
    output io_core_reset, io_dsp_reset, io_adcclkreset, io_ADCINP, io_ADCINM,
    input  io_ADCBIAS, io_success
  );

  modport slave (
    input  io_core_reset, io_dsp_reset, io_adcclkreset, io_ADCINP, io_ADCINM,
    output io_ADCBIAS, io_success
  );

endinterface

// File: rtl/craft_test_harness_crossing_detector.sv
// Hysteresis comparator plus rising-edge detect with a minimum-spacing filter;
// emits a one-cycle pulse for every accepted rising crossing.
module crossing_detector
  import craft_harness_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  input  logic  srst_i,
  input  diff_t diff_i,
  output logic  accept_o
);

  localparam diff_t       HYST_POS  = diff_t'(HYST);
  localparam diff_t       HYST_NEG  = diff_t'(-HYST);
  localparam logic [15:0] MIN_GAP_W = 16'(MIN_GAP);

  cmp_state_e  pos_q, pos_d, pos_prev_q;
  logic [15:0] gap_q, gap_d;
  logic        first_q, first_d;
  logic        rise;

  // Exactly +/-HYST sits inside the band and holds the previous decision.
  always_comb begin
    pos_d = pos_q;
    if (diff_i > HYST_POS) begin
      pos_d = POS;
    end else if (diff_i < HYST_NEG) begin
      pos_d = NEG;
    end

    rise     = (pos_q == POS) && (pos_prev_q == NEG);
    accept_o = rise && (!first_q || (gap_q >= MIN_GAP_W));
    first_d  = first_q | accept_o;

    gap_d = gap_q;
    if (accept_o) begin
      gap_d = '0;
    end else if (gap_q != 16'hFFFF) begin
      gap_d = gap_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pos_q      <= NEG;
      pos_prev_q <= NEG;
      gap_q      <= '0;
      first_q    <= 1'b0;
    end else if (srst_i) begin
      pos_q      <= NEG;
      pos_prev_q <= NEG;
      gap_q      <= '0;
      first_q    <= 1'b0;
    end else begin
      pos_q      <= pos_d;
      pos_prev_q <= pos_q;
      gap_q      <= gap_d;
      first_q    <= first_d;
    end
  end

endmodule

// File: rtl/craft_test_harness.sv
// Bring-up harness top: registers the differential ADC legs, counts accepted
// rising crossings and raises a sticky success flag.
module craft_test_harness
  import craft_harness_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  craft_test_harness_if.slave  bus
);

  localparam logic [7:0] NUM_W = 8'(NUM_CROSSINGS);

  logic [DATA_W-1:0] inp_q, inm_q;
  logic [7:0]        count_q, count_d;
  logic              success_q, success_d;
  logic              srst;
  logic              accept;
  diff_t             diff;

  // Core, DSP and ADC domains share this clock, so their resets just qualify it.
  assign srst = bus.io_core_reset | bus.io_dsp_reset | bus.io_adcclkreset;
  assign diff = $signed({1'b0, inp_q}) - $signed({1'b0, inm_q});

  assign bus.io_ADCBIAS = BIAS_CODE;
  assign bus.io_success = success_q;

  crossing_detector u_det (
    .clock    (clock),
    .reset    (reset),
    .srst_i   (srst),
    .diff_i   (diff),
    .accept_o (accept)
  );

  always_comb begin
    count_d = count_q;
    if (accept && (count_q < NUM_W)) begin
      count_d = count_q + 8'd1;
    end
    success_d = success_q | (count_q == NUM_W);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inp_q     <= '0;
      inm_q     <= '0;
      count_q   <= '0;
      success_q <= 1'b0;
    end else if (srst) begin
      inp_q     <= '0;
      inm_q     <= '0;
      count_q   <= '0;
      success_q <= 1'b0;
    end else begin
      inp_q     <= bus.io_ADCINP;
      inm_q     <= bus.io_ADCINM;
      count_q   <= count_d;
      success_q <= success_d;
    end
  end

endmodule

// File: tb/tb_craft_test_harness.sv
// Self-checking bench for craft_test_harness: cycle scoreboard plus hand-timed
// corner sequences for hysteresis, glitch filtering and the various resets.
module tb_craft_test_harness;
  import craft_harness_pkg::*;

  typedef struct {
    int   count;
    logic success;
  } exp_t;

  typedef struct {
    int   diff;
    logic expPos;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  craft_test_harness_if bus();

  craft_test_harness dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  int mInp, mInm, mGap, mCount;
  bit mPos, mPrev, mFirst, mSucc;
  int firstSucc;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s: actual %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic modelReset();
    mInp = 0; mInm = 0; mGap = 0; mCount = 0;
    mPos = 0; mPrev = 0; mFirst = 0; mSucc = 0;
  endtask

  task automatic checkOutput();
    exp_t e;
    if (expQ.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      e = expQ.pop_front();
      check("success", int'(bus.io_success), int'(e.success));
      check("count", int'(dut.count_q), e.count);
    end
    check("bias", int'(bus.io_ADCBIAS), 8'h80);
  endtask

  // Drive one sample (sr = {core, dsp, adcclk} resets), advance one edge, compare.
  task automatic applyStimulus(input int p, input int m, input logic [2:0] sr);
    exp_t e;
    int   d;
    bit   acc;
    bus.io_ADCINP      = 12'(p);
    bus.io_ADCINM      = 12'(m);
    bus.io_core_reset  = sr[2];
    bus.io_dsp_reset   = sr[1];
    bus.io_adcclkreset = sr[0];
    if (sr != 3'b000) begin
      modelReset();
    end else begin
      d     = mInp - mInm;
      acc   = mPos && !mPrev && (!mFirst || mGap >= MIN_GAP);
      mSucc = mSucc || (mCount == NUM_CROSSINGS);
      if (acc && mCount < NUM_CROSSINGS) mCount++;
      mGap   = acc ? 0 : ((mGap < 65535) ? mGap + 1 : mGap);
      mFirst = mFirst || acc;
      mPrev  = mPos;
      if (d > HYST) mPos = 1;
      else if (d < -HYST) mPos = 0;
      mInp = p;
      mInm = m;
    end
    e.count   = mCount;
    e.success = mSucc;
    expQ.push_back(e);
    @(posedge clock);
    #1;
    checkOutput();
    bus.io_core_reset  = 1'b0;
    bus.io_dsp_reset   = 1'b0;
    bus.io_adcclkreset = 1'b0;
  endtask

  task automatic squareStep(input int c, input logic [2:0] sr);
    if ((c % 20) < 10) applyStimulus(2148, 1948, sr);
    else               applyStimulus(1948, 2148, sr);
  endtask

  task automatic asyncReset();
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("async_success", int'(bus.io_success), 0);
    check("async_bias", int'(bus.io_ADCBIAS), 8'h80);
    #1;
    reset = 1'b0;
    modelReset();
  endtask

  initial begin
    vec_t vecs[10];
    int   expCnt;

    vecs[0] = '{200, 1'b1};
    vecs[1] = '{16, 1'b1};
    vecs[2] = '{-16, 1'b1};
    vecs[3] = '{-17, 1'b0};
    vecs[4] = '{-16, 1'b0};
    vecs[5] = '{16, 1'b0};
    vecs[6] = '{17, 1'b1};
    vecs[7] = '{0, 1'b1};
    vecs[8] = '{-200, 1'b0};
    vecs[9] = '{100, 1'b1};

    bus.io_core_reset  = 1'b0;
    bus.io_dsp_reset   = 1'b0;
    bus.io_adcclkreset = 1'b0;
    bus.io_ADCINP      = 12'd2048;
    bus.io_ADCINM      = 12'd2048;
    modelReset();

    repeat (3) begin
      @(negedge clock);
      check("reset_bias", int'(bus.io_ADCBIAS), 8'h80);
      check("reset_success", int'(bus.io_success), 0);
    end
    reset = 1'b0;

    // Constant input: no crossings, no success.
    for (int c = 0; c < 1000; c++) applyStimulus(2048, 2048, 3'b000);
    check("idle_success", int'(bus.io_success), 0);

    // Comparator table: each level held long enough to settle.
    for (int i = 0; i < 10; i++) begin
      repeat (3) applyStimulus(2048 + vecs[i].diff, 2048, 3'b000);
      check("hyst_vec", int'(dut.u_det.pos_q), int'(vecs[i].expPos));
    end
    asyncReset();

    // Clean square wave, then a core reset after success.
    firstSucc = -1;
    for (int c = 0; c < 70; c++) begin
      squareStep(c, 3'b000);
      if (bus.io_success && firstSucc < 0) firstSucc = c;
    end
    check("square_succ_cycle", firstSucc, 63);
    check("square_count_sat", int'(dut.count_q), 4);
    squareStep(70, 3'b100);
    check("core_srst_drop", int'(bus.io_success), 0);
    asyncReset();

    // Mid-run DSP reset after three crossings.
    firstSucc = -1;
    for (int c = 0; c < 131; c++) begin
      if (c == 50) check("pre_srst_count", int'(dut.count_q), 3);
      squareStep(c, (c == 50) ? 3'b010 : 3'b000);
      if (c == 50) check("post_srst_count", int'(dut.count_q), 0);
      if (bus.io_success && firstSucc < 0) firstSucc = c;
    end
    check("midrun_succ_cycle", firstSucc, 123);

    check("pre_async_success", int'(bus.io_success), 1);
    asyncReset();

    // Diff sitting exactly on the band edges never switches the comparator.
    for (int c = 0; c < 500; c++) applyStimulus(((c % 2) == 0) ? 2064 : 2032, 2048, 3'b000);
    check("band_success", int'(bus.io_success), 0);
    check("band_count", int'(dut.count_q), 0);
    firstSucc = -1;
    for (int c = 0; c < 70; c++) begin
      applyStimulus(((c % 20) < 10) ? 2065 : 2031, 2048, 3'b000);
      if (bus.io_success && firstSucc < 0) firstSucc = c;
    end
    check("band17_succ_cycle", firstSucc, 63);

    // Glitch filter: rises every 2 cycles, accepted ones land 10 cycles apart.
    applyStimulus(2048, 2048, 3'b001);
    firstSucc = -1;
    for (int c = 0; c < 40; c++) begin
      applyStimulus(((c % 2) == 0) ? 2148 : 1948, 2048, 3'b000);
      expCnt = (c < 2) ? 0 : (c < 12) ? 1 : (c < 22) ? 2 : (c < 32) ? 3 : 4;
      check("glitch_count", int'(dut.count_q), expCnt);
      if (bus.io_success && firstSucc < 0) firstSucc = c;
    end
    check("glitch_succ_cycle", firstSucc, 33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
